// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
//   Shared types and defaults for the PC fetch sequencer.
//   - state_e : fetch FSM states (BOOT, FETCH, PEND)
//   - sel_e   : next-PC source encoding, lowest to highest priority
//   - PC_RESET_VEC / PC_INC : default reset vector and sequential increment
// -----------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    PEND  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_JABS = 2'd1,
    SEL_RIND = 2'd2,
    SEL_BR   = 2'd3
  } sel_e;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam int unsigned PC_INC       = 4;

endpackage : pc_pkg

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
//   Purely combinational next-PC source select. Priority is
//   branch > register-indirect > absolute jump. The chosen target has its
//   two low bits cleared so fetch addresses are always word aligned.
//
// Ports
//   pcsrc, jr, jump : redirect requests (branch taken, jump-register, jump)
//   br, rind, jabs  : corresponding targets
//   redirect        : any redirect request present
//   target          : selected, word-aligned redirect target
// -----------------------------------------------------------------------------
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             pcsrc,
  input  logic             jr,
  input  logic             jump,
  input  logic [WIDTH-1:0] br,
  input  logic [WIDTH-1:0] rind,
  input  logic [WIDTH-1:0] jabs,
  output logic             redirect,
  output logic [WIDTH-1:0] target
);

  sel_e             sel;
  logic [WIDTH-1:0] raw;

  always_comb begin
    if (pcsrc)     sel = SEL_BR;
    else if (jr)   sel = SEL_RIND;
    else if (jump) sel = SEL_JABS;
    else           sel = SEL_SEQ;
  end

  // NOTE: every always_comb output gets a value on every path (here via a
  // default arm) so no latch is inferred.
  always_comb begin
    unique case (sel)
      SEL_BR:   raw = br;
      SEL_RIND: raw = rind;
      default:  raw = jabs;
    endcase
  end

  assign redirect = (sel != SEL_SEQ);
  assign target   = raw & ~WIDTH'(3);

endmodule : pc_next_sel

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//   Owns the program counter and sequences instruction fetch over a req/gnt
//   handshake. A request, once raised, holds its address until granted; a
//   redirect arriving while a request is ungranted is parked in a pending
//   register (PEND) and applied when the wrong-path fetch is granted.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall               : hazard hold, blocks new requests (not issued ones)
//   pcsrc, jr, jump     : redirect requests; br, rind, jabs their targets
//   imem_gnt            : memory accepts the current request
//   imem_req, imem_addr : fetch request and address (address == pc)
//   pc, pc_plus_4       : current PC and PC + INC
//   flush               : one-cycle IF/ID squash per accepted redirect
//   fetch_keep          : the transaction granted this cycle is valid
//
// Optional (macro PC_REDIRECT_CNT_EN defined):
//   redirect_cnt        : saturating count of accepted redirects
//   stall_cnt           : saturating count of cycles with stall and no request
// -----------------------------------------------------------------------------
module pc_fetch_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter int unsigned      INC       = PC_INC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             pcsrc,
  input  logic             jr,
  input  logic             jump,
  input  logic [WIDTH-1:0] br,
  input  logic [WIDTH-1:0] rind,
  input  logic [WIDTH-1:0] jabs,
  input  logic             imem_gnt,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_4,
  output logic             flush,
  output logic             fetch_keep
`ifdef PC_REDIRECT_CNT_EN
  ,
  output logic [31:0]      redirect_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pend_q;
  logic             hold_q;    // request raised last cycle, not yet granted
  logic             redirect;
  logic [WIDTH-1:0] target;
  logic             outstanding;

  pc_next_sel #(.WIDTH(WIDTH)) u_next_sel (
    .pcsrc    (pcsrc),
    .jr       (jr),
    .jump     (jump),
    .br       (br),
    .rind     (rind),
    .jabs     (jabs),
    .redirect (redirect),
    .target   (target)
  );

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign pc_plus_4 = pc_q + WIDTH'(INC);

  // Handshake outputs depend on this cycle's gnt/redirect, so they are
  // decoded from the registered state rather than registered themselves.
  always_comb begin
    imem_req   = 1'b0;
    flush      = 1'b0;
    fetch_keep = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req   = !stall || hold_q;
        flush      = redirect;
        fetch_keep = imem_req && imem_gnt && !redirect;
      end
      PEND: begin
        // Wrong-path request must still complete; its data is dropped.
        imem_req = 1'b1;
      end
      default: ;
    endcase
  end

  // A request on the bus this cycle that is not being granted pins pc.
  assign outstanding = imem_req && !imem_gnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      pend_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      hold_q <= outstanding;
      unique case (state_q)
        BOOT: state_q <= FETCH;
        FETCH: begin
          if (redirect) begin
            if (outstanding) begin
              pend_q  <= target;
              state_q <= PEND;
            end else begin
              pc_q <= target;
            end
          end else if (imem_req && imem_gnt) begin
            pc_q <= pc_plus_4;
          end
        end
        PEND: begin
          // Younger redirects are ignored: the parked one already flushed them.
          if (imem_gnt) begin
            pc_q    <= pend_q;
            state_q <= FETCH;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

`ifdef PC_REDIRECT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (flush && (redirect_cnt != '1))
        redirect_cnt <= redirect_cnt + 32'd1;
      if (stall && !imem_req && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule : pc_fetch_sequencer
